config_loader: RTL and testbench

Serial bitstream loader sitting directly upstream of the logic tile configuration chain. It accepts configuration words from a host over a valid/ready handshake and shifts them MSB-first onto the chain's `config_in` with `config_enable` and `config_nreset`. It also counts exactly the number of chain bits, so each tile's 524-bit shift register ends up fully and correctly loaded. It reports busy/done status and, optionally, a CRC error flag.

---
 rtl/config_loader_pkg.sv | 25 ++
 rtl/config_loader_if.sv | 24 ++
 rtl/config_loader_crc16.sv | 30 +++
 rtl/config_loader.sv | 198 +++++++++++++++++++
 tb/tb_config_loader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/config_loader_pkg.sv
// rtl/config_loader_pkg.sv - shared types, constants and helpers for the configuration loader
// Contents: loader state enum, CRC-16-CCITT constants, CLEAR length, ceil-divide helper.
package config_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Cycles the chain clear (config_nreset) is held low at the start of a load.
  localparam int CLEAR_CYCLES = 2;

  // Number of host words needed to cover a chain of num bits.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/config_loader_if.sv
// rtl/config_loader_if.sv - host word handshake bundle for the configuration loader
// Signals: word_data (MSB shifted first), word_valid (host), word_ready (loader).
// Modports: master = host side, slave = loader side.
interface config_loader_if #(
  parameter int WORD_WIDTH = 8
);

  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/config_loader_crc16.sv
// rtl/config_loader_crc16.sv - bit-serial CRC-16-CCITT accumulator, MSB first
// Used by config_loader only when CONFIG_LOADER_CRC_EN is defined.
// Ports: clock, nreset (async active-low), clear (reload init), enable (absorb din),
//        din (serial payload bit), crc (running remainder).
module config_loader_crc16
  import config_loader_pkg::*;
(
  input  logic        clock,
  input  logic        nreset,
  input  logic        clear,
  input  logic        enable,
  input  logic        din,
  output logic [15:0] crc
);

  logic feedback;

  assign feedback = crc[15] ^ din;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/config_loader.sv
// rtl/config_loader.sv - serial bitstream loader for the tile configuration chain
// Accepts host words over host (config_loader_if.slave) and shifts them MSB-first
// onto the chain, pulsing config_enable exactly TILE_COUNT*TILE_BITS times per load.
// Ports: clock, nreset (async active-low), start, host (word_data/valid/ready),
//        config_out, config_enable, config_nreset (chain side),
//        busy, done, error (status).
// Optional feature: CONFIG_LOADER_CRC_EN adds a 16-bit CRC trailer check; when
// undefined, error is tied low and no trailer words are accepted.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int TILE_COUNT = 1,
  parameter int TILE_BITS  = 524,
  parameter int WORD_WIDTH = 8
) (
  input  logic           clock,
  input  logic           nreset,
  input  logic           start,
  config_loader_if.slave host,
  output logic           config_out,
  output logic           config_enable,
  output logic           config_nreset,
  output logic           busy,
  output logic           done,
  output logic           error
);

  localparam int CHAIN_LENGTH = TILE_COUNT * TILE_BITS;
  localparam int CNT_W        = $clog2(CHAIN_LENGTH + 1);
  localparam int BIT_W        = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int CLR_W        = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  state_t                  state;
  state_t                  state_n;
  logic [WORD_WIDTH-1:0]   shift_reg;
  logic [CNT_W-1:0]        bit_cnt;      // bits already shifted this load
  logic [BIT_W-1:0]        bit_in_word;  // position within the current word
  logic [CLR_W-1:0]        clear_cnt;

  logic start_accept;
  logic clear_last;
  logic last_bit;
  logic word_end;

  assign start_accept = start && (state == ST_IDLE || state == ST_DONE);
  assign clear_last   = (clear_cnt == CLR_W'(CLEAR_CYCLES - 1));
  // The chain length, not the word boundary, ends the payload, so a final
  // partial word has its low bits dropped.
  assign last_bit     = (bit_cnt == CNT_W'(CHAIN_LENGTH - 1));
  assign word_end     = (bit_in_word == BIT_W'(WORD_WIDTH - 1));

`ifdef CONFIG_LOADER_CRC_EN
  localparam int TRAILER_WORDS = 16 / WORD_WIDTH;

  logic        trailer_phase;  // payload finished; LOAD now collects CRC words
  logic [0:0]  trailer_cnt;
  logic [15:0] expected_crc;
  logic [15:0] computed_crc;
  logic        error_q;

  config_loader_crc16 u_crc16 (
    .clock  (clock),
    .nreset (nreset),
    .clear  (start_accept),
    .enable (state == ST_SHIFT),
    .din    (shift_reg[WORD_WIDTH-1]),
    .crc    (computed_crc)
  );

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_n = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clear_last) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        if (host.word_valid) begin
`ifdef CONFIG_LOADER_CRC_EN
          if (!trailer_phase) begin
            state_n = ST_SHIFT;
          end else if (trailer_cnt == 1'(TRAILER_WORDS - 1)) begin
            state_n = ST_CHECK;
          end
`else
          state_n = ST_SHIFT;
`endif
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
`ifdef CONFIG_LOADER_CRC_EN
          state_n = ST_LOAD;
`else
          state_n = ST_DONE;
`endif
        end else if (word_end) begin
          state_n = ST_LOAD;
        end
      end
      ST_CHECK: begin
        state_n = ST_DONE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      shift_reg     <= '0;
      bit_cnt       <= '0;
      bit_in_word   <= '0;
      clear_cnt     <= '0;
`ifdef CONFIG_LOADER_CRC_EN
      trailer_phase <= 1'b0;
      trailer_cnt   <= '0;
      expected_crc  <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            bit_cnt       <= '0;
            clear_cnt     <= '0;
`ifdef CONFIG_LOADER_CRC_EN
            trailer_phase <= 1'b0;
            trailer_cnt   <= '0;
            error_q       <= 1'b0;
`endif
          end
        end
        ST_CLEAR: begin
          clear_cnt <= clear_cnt + CLR_W'(1);
        end
        ST_LOAD: begin
          if (host.word_valid) begin
`ifdef CONFIG_LOADER_CRC_EN
            if (trailer_phase) begin
              // Trailer words arrive MSB first; keep the low 16 bits.
              expected_crc <= 16'({expected_crc, host.word_data});
              trailer_cnt  <= trailer_cnt + 1'b1;
            end else begin
              shift_reg   <= host.word_data;
              bit_in_word <= '0;
            end
`else
            shift_reg   <= host.word_data;
            bit_in_word <= '0;
`endif
          end
        end
        ST_SHIFT: begin
          shift_reg   <= {shift_reg[WORD_WIDTH-2:0], 1'b0};
          bit_cnt     <= bit_cnt + CNT_W'(1);
          bit_in_word <= bit_in_word + BIT_W'(1);
`ifdef CONFIG_LOADER_CRC_EN
          if (last_bit) trailer_phase <= 1'b1;
`endif
        end
        ST_CHECK: begin
`ifdef CONFIG_LOADER_CRC_EN
          error_q <= (expected_crc != computed_crc);
`endif
        end
        default: begin
        end
      endcase
    end
  end

  // All outputs decode registered state only.
  assign host.word_ready = (state == ST_LOAD);
  assign config_enable   = (state == ST_SHIFT);
  assign config_out      = (state == ST_SHIFT) && shift_reg[WORD_WIDTH-1];
  assign config_nreset   = (state != ST_CLEAR);
  assign busy            = (state == ST_CLEAR) || (state == ST_LOAD) ||
                           (state == ST_SHIFT) || (state == ST_CHECK);
  assign done            = (state == ST_DONE);

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - randomized self-checking bench for config_loader
// Reference: expected serial stream, chain image, CRC and timing are computed from
// the word list with plain loops; a 524-bit chain model follows config_enable.
module tb_config_loader;
  import config_loader_pkg::*;

  localparam int TILE_COUNT = 1;
  localparam int TILE_BITS  = 524;
  localparam int WW         = 8;
  localparam int CHAIN      = TILE_COUNT * TILE_BITS;
  localparam int NW         = ceil_div(CHAIN, WW);
  localparam int LASTB      = CHAIN - (NW - 1) * WW;
`ifdef CONFIG_LOADER_CRC_EN
  localparam int NTR = 16 / WW;
  localparam int CHK = 1;
`else
  localparam int NTR = 0;
  localparam int CHK = 0;
`endif
  localparam int BUDGET = 5000;

  logic clock = 1'b0;
  logic nreset;
  logic start;
  logic config_out, config_enable, config_nreset, busy, done, error;

  config_loader_if #(.WORD_WIDTH(WW)) bus ();

  config_loader #(
    .TILE_COUNT (TILE_COUNT),
    .TILE_BITS  (TILE_BITS),
    .WORD_WIDTH (WW)
  ) dut (
    .clock         (clock),
    .nreset        (nreset),
    .start         (start),
    .host          (bus),
    .config_out    (config_out),
    .config_enable (config_enable),
    .config_nreset (config_nreset),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [WW-1:0]    wq[$];
  logic             stream_q[$];
  int               en_cnt;
  int               clr_cnt;
  logic [CHAIN-1:0] chain;

  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Observes each cycle mid-period; the chain model shifts toward the last tile.
  always @(negedge clock) begin
    if (config_enable) begin
      stream_q.push_back(config_out);
      en_cnt++;
    end
    if (!config_nreset) begin
      clr_cnt++;
      chain = '0;
    end else if (config_enable) begin
      chain = {chain[CHAIN-2:0], config_out};
    end
  end

  function automatic logic [639:0] payload_vec();
    logic [639:0] v;
    v = '0;
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < WW; b++)
        if (w * WW + b < CHAIN) v[w * WW + b] = wq[w][WW-1-b];
    return v;
  endfunction

  function automatic logic [15:0] crc_ref(input logic [639:0] v);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int j = 0; j < CHAIN; j++)
      c = (c[15] ^ v[j]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic build(input bit directed, input bit corrupt);
    logic [15:0] c;
    wq.delete();
    for (int w = 0; w < NW; w++)
      wq.push_back(directed ? ((w == NW - 1) ? WW'('hF0) : WW'('hA5)) : WW'($urandom));
    c = crc_ref(payload_vec());
    for (int t = 0; t < NTR; t++) wq.push_back(WW'(c >> (16 - (t + 1) * WW)));
    if (corrupt) wq[17 / WW][WW-1-(17 % WW)] = ~wq[17 / WW][WW-1-(17 % WW)];
  endtask

  task automatic check_reset(input string name);
    check({name, "_config_out"},    config_out,      0);
    check({name, "_config_enable"}, config_enable,   0);
    check({name, "_config_nreset"}, config_nreset,   1);
    check({name, "_word_ready"},    bus.word_ready,  0);
    check({name, "_busy"},          busy,            0);
    check({name, "_done"},          done,            0);
    check({name, "_error"},         error,           0);
  endtask

  task automatic run_load(input string name, input bit rand_bp, input int gap_word,
                          input bit poke_start, input int abort_at);
    int i, cyc, first_load, en0, gap_left;
    bit gap_active, gap_done, gap_checked, poked, exp_err;
    logic [639:0] exp_vec, got_vec, exp_chain;
    logic [15:0] tr;
    i = 0; cyc = 0; first_load = -1; en0 = 0; gap_left = 0;
    gap_active = 0; gap_done = 0; gap_checked = 0; poked = 0;
    exp_vec = payload_vec();
    exp_err = 0;
    tr = '0;
    for (int t = 0; t < NTR; t++) tr = (tr << WW) | 16'(wq[NW + t]);
    if (NTR > 0) exp_err = (tr != crc_ref(exp_vec));
    exp_chain = '0;
    for (int j = 0; j < CHAIN; j++) exp_chain[CHAIN-1-j] = exp_vec[j];
    stream_q.delete();
    en_cnt = 0;
    clr_cnt = 0;

    start = 1'b1;
    bus.word_valid = 1'b0;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < BUDGET) begin
      if (bus.word_ready && first_load < 0) first_load = cyc;
      if (abort_at > 0 && en_cnt >= abort_at) begin
        check({name, "_pre_abort_enable"}, config_enable, 1);
        check({name, "_pre_abort_count"}, en_cnt, abort_at);
        nreset = 1'b0;
        #1;
        check_reset({name, "_async"});
        repeat (3) tick();
        nreset = 1'b1;
        bus.word_valid = 1'b0;
        tick();
        check({name, "_idle_busy"}, busy, 0);
        return;
      end
      start = 1'b0;
      if (poke_start && !poked && config_enable && en_cnt > 40) begin
        start = 1'b1;
        poked = 1;
      end
      if (gap_word >= 0 && !gap_done && !gap_active && i == gap_word && bus.word_ready) begin
        gap_active = 1;
        gap_left = 5;
        en0 = en_cnt;
      end
      if (gap_active) begin
        bus.word_valid = 1'b0;
        gap_left--;
        if (gap_left == 0) begin
          gap_active = 0;
          gap_done = 1;
        end
      end else begin
        bus.word_valid = (i < wq.size()) && (!rand_bp || $urandom_range(0, 3) != 0);
      end
      bus.word_data = (i < wq.size()) ? wq[i] : WW'($urandom);
      if (bus.word_valid && bus.word_ready) i++;
      tick();
      cyc++;
      if (gap_done && !gap_checked) begin
        check({name, "_gap_enables"}, en_cnt - en0, 0);
        check({name, "_gap_ready"}, bus.word_ready, 1);
        gap_checked = 1;
      end
    end
    bus.word_valid = 1'b0;
    start = 1'b0;

    check({name, "_done"}, done, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_error"}, error, exp_err);
    check({name, "_enable_count"}, en_cnt, CHAIN);
    check({name, "_clear_cycles"}, clr_cnt, CLEAR_CYCLES);
    check({name, "_words_taken"}, i, NW + NTR);
    got_vec = '0;
    for (int j = 0; j < stream_q.size() && j < CHAIN; j++) got_vec[j] = stream_q[j];
    check({name, "_stream"}, got_vec, exp_vec);
    check({name, "_chain"}, 640'(chain), exp_chain);
    if (!rand_bp && gap_word < 0) begin
      check({name, "_first_load_cycle"}, first_load, 3);
      check({name, "_done_cycle"}, cyc, 3 + (NW - 1) * (WW + 1) + 1 + LASTB + NTR + CHK);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0;
    start = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_data = '0;
    repeat (3) tick();
    check_reset("por");
    nreset = 1'b1;
    tick();
    check("post_reset_busy", busy, 0);
    check("post_reset_ready", bus.word_ready, 0);

    build(1, 0);
    run_load("full", 0, -1, 0, 0);
    check("full_bit523", chain[CHAIN-1], 1);
    repeat (4) tick();
    check("full_done_held", done, 1);

    build(0, 0);
    run_load("gap", 0, 11, 0, 0);

    build(0, 0);
    run_load("start_poke", 0, -1, 1, 0);

    build(0, 0);
    run_load("abort", 0, -1, 0, 200);
    build(0, 0);
    run_load("restart", 0, -1, 0, 0);

    for (int k = 0; k < 3; k++) begin
      build(0, 0);
      run_load("rand_bp", 1, -1, 0, 0);
    end

`ifdef CONFIG_LOADER_CRC_EN
    build(0, 1);
    run_load("crc_bad", 1, -1, 0, 0);
    check("crc_bad_flag", error, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
